// File: rtl/ue14500_sequencer.sv
// Fetch/sequencing stage for the ue14500 1-bit core: program counter, single-entry
// return register, two-clock execute window and the pin/latch/scratch I/O mux.
module ue14500_sequencer #(
  parameter int PC_W = 6,
  parameter int IO_N = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            run,
  output logic [PC_W-1:0] rom_addr,
  input  logic [7:0]      rom_data,
  output logic [3:0]      core_instr,
  output logic            core_step,
  output logic            core_din,
  input  logic            core_wr,
  input  logic            core_dout,
  input  logic            core_jmp,
  input  logic            core_rtn,
  input  logic [IO_N-1:0] in_pins,
  output logic [IO_N-1:0] out_pins,
  output logic            halted
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    EXEC0 = 3'd2,
    EXEC1 = 3'd3,
    JTGT  = 3'd4
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [PC_W-1:0] pc;
  logic [PC_W-1:0] ret;
  logic [7:0]      ir;
  logic [IO_N-1:0] scratch;
  logic [IO_N-1:0] out_q;
  logic [2:0]      sel;
  logic            din_sel;

  assign sel = ir[2:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // A jump always passes through JTGT so the target word is consumed even when stopping.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (run) state_nxt = FETCH;
      FETCH:   state_nxt = EXEC0;
      EXEC0:   state_nxt = EXEC1;
      EXEC1: begin
        if (core_jmp)      state_nxt = JTGT;
        else if (core_rtn) state_nxt = FETCH;
        else if (!run)     state_nxt = IDLE;
        else               state_nxt = FETCH;
      end
      JTGT:    state_nxt = run ? FETCH : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    core_step = 1'b0;
    halted    = 1'b0;
    din_sel   = ir[3] ? scratch[sel] : in_pins[sel];
    case (state)
      IDLE:          halted    = 1'b1;
      EXEC0, EXEC1:  core_step = 1'b1;
      default: ;
    endcase
    core_din = core_step & din_sel;
  end

  // Store precedes control flow at the EXEC1 edge; jmp outranks rtn.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc      <= '0;
      ret     <= '0;
      ir      <= '0;
      scratch <= '0;
      out_q   <= '0;
    end else begin
      case (state)
        FETCH: ir <= rom_data;
        EXEC1: begin
          if (core_wr) begin
            if (ir[3]) scratch[sel] <= core_dout;
            else       out_q[sel]   <= core_dout;
          end
          if (core_jmp) begin
            ret <= pc + PC_W'(2);
            pc  <= pc + PC_W'(1);
          end else if (core_rtn) begin
            pc  <= ret;
          end else begin
            pc  <= pc + PC_W'(1);
          end
        end
        JTGT: pc <= rom_data[PC_W-1:0];
        default: ;
      endcase
    end
  end

  assign rom_addr   = pc;
  assign core_instr = ir[7:4];
  assign out_pins   = out_q;

endmodule

// File: tb/tb_ue14500_sequencer.sv
// Scoreboard bench for ue14500_sequencer: an instruction-level program model predicts
// every execute window (address, opcode, data bit, latch state, spacing).
module tb_ue14500_sequencer;
  localparam int PC_W = 6;
  localparam int IO_N = 8;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            run;
  logic [PC_W-1:0] rom_addr;
  logic [7:0]      rom_data;
  logic [3:0]      core_instr;
  logic            core_step;
  logic            core_din;
  logic            core_wr = 1'b0;
  logic            core_dout = 1'b0;
  logic            core_jmp = 1'b0;
  logic            core_rtn = 1'b0;
  logic [IO_N-1:0] in_pins;
  logic [IO_N-1:0] out_pins;
  logic            halted;

  ue14500_sequencer #(.PC_W(PC_W), .IO_N(IO_N)) dut (
    .clk(clk), .rst_n(rst_n), .run(run),
    .rom_addr(rom_addr), .rom_data(rom_data),
    .core_instr(core_instr), .core_step(core_step), .core_din(core_din),
    .core_wr(core_wr), .core_dout(core_dout), .core_jmp(core_jmp), .core_rtn(core_rtn),
    .in_pins(in_pins), .out_pins(out_pins), .halted(halted)
  );

  always #5 clk = ~clk;

  logic [7:0] rom [0:63];
  assign rom_data = rom[rom_addr];

  typedef struct {
    logic [5:0] addr;
    logic [3:0] op;
    logic       din;
    logic [7:0] outp;
    int         gap;
  } exp_t;

  exp_t       sb[$];
  logic [3:0] fq[$];   // {jmp, rtn, wr, dout} per executed instruction

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_assert++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, req);
    end
  endtask

  // Program-level reference: one call per executed instruction.
  logic [5:0] m_pc, m_ret;
  logic [7:0] m_out, m_scr;
  bit         m_prevjmp, m_first;

  task automatic model_step(input logic [3:0] f);
    exp_t       e;
    logic [7:0] w;
    logic [7:0] tgt;
    w      = rom[m_pc];
    e.addr = m_pc;
    e.op   = w[7:4];
    e.din  = w[3] ? m_scr[w[2:0]] : in_pins[w[2:0]];
    e.outp = m_out;
    e.gap  = m_first ? 0 : (m_prevjmp ? 4 : 3);
    sb.push_back(e);
    fq.push_back(f);
    m_first = 0;
    if (f[1]) begin
      if (w[3]) m_scr[w[2:0]] = f[0];
      else      m_out[w[2:0]] = f[0];
    end
    m_prevjmp = f[3];
    if (f[3]) begin
      tgt   = rom[m_pc + 6'd1];
      m_ret = m_pc + 6'd2;
      m_pc  = tgt[5:0];
    end else if (f[2]) begin
      m_pc = m_ret;
    end else begin
      m_pc = m_pc + 6'd1;
    end
  endtask

  // Core stand-in: drives flags during EXEC1 from the flag queue.
  bit   drv_en = 0;
  logic f_wr = 1'b0, f_dout = 1'b0;
  initial begin
    logic       d_prev;
    logic [3:0] f;
    d_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!drv_en) begin
        {core_jmp, core_rtn, core_wr, core_dout} = {2'b00, f_wr, f_dout};
      end else if (core_step && d_prev) begin
        f = (fq.size() != 0) ? fq.pop_front() : 4'h0;
        {core_jmp, core_rtn, core_wr, core_dout} = f;
      end else begin
        {core_jmp, core_rtn, core_wr, core_dout} = 4'h0;
      end
      d_prev = core_step;
    end
  end

  // Monitor: each execute window pops one expectation.
  bit         mon_en = 0;
  int         m_cnt  = 0;
  initial begin
    int         cyc, last;
    logic       prev;
    logic [5:0] faddr;
    exp_t       cur;
    cyc = 0; last = 0; prev = 1'b0; faddr = '0;
    cur = '{addr: '0, op: '0, din: 1'b0, outp: '0, gap: 0};
    forever begin
      @(negedge clk);
      cyc++;
      if (!core_step && !halted) faddr = rom_addr;
      if (mon_en && core_step && !prev) begin
        if (sb.size() == 0) begin
          chk("unexpected_exec", 32'd1, 32'd0);
        end else begin
          cur = sb.pop_front();
          chk("fetch_addr", 32'(faddr), 32'(cur.addr));
          chk("core_instr", 32'(core_instr), 32'(cur.op));
          chk("core_din", 32'(core_din), 32'(cur.din));
          chk("out_pins", 32'(out_pins), 32'(cur.outp));
          if (cur.gap != 0) chk("exec_spacing", 32'(cyc - last), 32'(cur.gap));
        end
        last = cyc;
        m_cnt++;
      end else if (mon_en && core_step && prev) begin
        chk("instr_hold", 32'(core_instr), 32'(cur.op));
      end
      prev = core_step;
    end
  end

  task automatic run_phase(input int n);
    int target;
    target = m_cnt + n;
    run = 1'b1;
    for (int i = 0; i < 20 * n && m_cnt < target; i++) @(negedge clk);
    chk("phase_exec_count", 32'(m_cnt >= target), 32'd1);
    run = 1'b0;
    for (int i = 0; i < 20 && !halted; i++) @(negedge clk);
    repeat (6) @(negedge clk);
    chk("stop_halted", 32'(halted), 32'd1);
    chk("stop_step", 32'(core_step), 32'd0);
    chk("stop_out_pins", 32'(out_pins), 32'(m_out));
    chk("sb_drained", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] dflags [0:10];
    logic [3:0] f;
    int         r;
    rst_n = 1'b0; run = 1'b0; in_pins = '0;
    for (int i = 0; i < 64; i++) rom[i] = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_halted", 32'(halted), 32'd1);
    chk("rst_step", 32'(core_step), 32'd0);
    chk("rst_rom_addr", 32'(rom_addr), 32'd0);
    chk("rst_out_pins", 32'(out_pins), 32'd0);
    chk("rst_instr", 32'(core_instr), 32'd0);

    // Reset during EXEC1 of a pin-5 store must leave no trace.
    rst_n = 1'b1; rom[0] = 8'h85; f_wr = 1'b1; f_dout = 1'b1; run = 1'b1;
    for (int i = 0; i < 20 && !core_step; i++) @(negedge clk);
    chk("reach_exec0", 32'(core_step), 32'd1);
    @(negedge clk);
    chk("exec1_wr_driven", 32'(core_wr), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_out_pins", 32'(out_pins), 32'd0);
    chk("midrst_halted", 32'(halted), 32'd1);
    chk("midrst_rom_addr", 32'(rom_addr), 32'd0);
    chk("midrst_step", 32'(core_step), 32'd0);
    chk("midrst_instr", 32'(core_instr), 32'd0);
    run = 1'b0; f_wr = 1'b0; f_dout = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk("postrst_out_pins", 32'(out_pins), 32'd0);

    m_pc = '0; m_ret = '0; m_out = '0; m_scr = '0; m_prevjmp = 0;
    drv_en = 1; mon_en = 1;

    // Directed program: linear, JMP/RTN, I/O mux, scratch, jmp+rtn conflict, wrap, stop.
    rom[0] = 8'h10; rom[1] = 8'h85; rom[2] = 8'h00; rom[3] = 8'hC0; rom[4] = 8'h2A;
    rom[42] = 8'hD0; rom[5] = 8'h16; rom[6] = 8'h8B; rom[7] = 8'h1B; rom[8] = 8'hC0;
    rom[9] = 8'h3F; rom[63] = 8'h10;
    dflags = '{4'h0, 4'h3, 4'h0, 4'h8, 4'h4, 4'h0, 4'h3, 4'h0, 4'hC, 4'h0, 4'h0};
    in_pins = 8'b0100_0000;
    m_first = 1;
    for (int k = 0; k < 11; k++) model_step(dflags[k]);
    run_phase(11);
    chk("directed_out_pins", 32'(out_pins), 32'h20);

    // Random programs, continuing from where the previous phase stopped.
    for (int p = 0; p < 3; p++) begin
      for (int i = 0; i < 64; i++) rom[i] = 8'($urandom);
      in_pins = 8'($urandom);
      m_first = 1;
      for (int k = 0; k < 120; k++) begin
        r = int'($urandom_range(0, 11));
        f[3] = (r <= 1);
        f[2] = (r == 0) || (r == 2) || (r == 3);
        f[1:0] = 2'($urandom);
        if (k == 119) f[3:2] = 2'b00;
        model_step(f);
      end
      run_phase(120);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
